if_fetch_unit: RTL and testbench

// - Instruction-fetch front end of the RV32I pipeline inside cpu_top_soc.
// - Generates the PC and issues word reads to the synchronous instruction ROM (u_rom).
// - Buffers returned {pc, inst} pairs in a small skid FIFO.
// - Hands them to the decode stage over a valid/ready handshake, and absorbs

---
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, synchronous ROM requests,
// skid FIFO of {pc, inst} and valid/ready hand-off to decode with redirect flush.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 12,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              jump_en,
  input  logic [31:0]       jump_addr,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              misalign_err
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_O = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW:0]   occ;
  logic [CW:0]   occ_left;
  logic          pop;
  logic          push;
  logic          full;

  assign full     = (count_q == DEPTH_C);
  assign if_valid = (count_q != '0) & !jump_en;
  assign pop      = if_valid & id_ready;
  assign push     = inflight_q & !jump_en;
  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign occ_left = occ - {{CW{1'b0}}, pop};
  assign rom_en   = rst & !jump_en & (occ_left < DEPTH_O);
  assign rom_addr = fetch_pc[ROM_AW+1:2];
  assign if_pc    = mem_pc[head_q];
  assign if_inst  = if_valid ? mem_inst[head_q] : NOP;

  // PC sequencing, in-flight request tracking and redirect capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc      <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else if (jump_en) begin
      fetch_pc   <= {jump_addr[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rom_en;
      if (rom_en) begin
        inflight_pc_q <= fetch_pc;
        fetch_pc      <= fetch_pc + 32'd4;
      end
    end
  end

  // Sticky flag for a redirect target that is not word aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
    end else if (jump_en && (jump_addr[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  // Skid FIFO: a redirect drops every buffered entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= RESET_PC;
        mem_inst[i] <= NOP;
      end
    end else if (jump_en) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_pc[tail_q]   <= inflight_pc_q;
        mem_inst[tail_q] <= rom_inst;
        tail_q           <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  ovf_chk: assert property (@(posedge clk) disable iff (!rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle-table vectors for the startup, stall,
// redirect and reset corner cases, a PC-stream scoreboard and a random phase.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [31:0] rom_inst = 32'h0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign_err;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_chk = 0;
  int n_fail = 0;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (12),
    .DEPTH    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_inst     (rom_inst),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with ROM[k] = k+1
  always @(posedge clk) begin
    if (rom_en) rom_inst <= {20'h0, rom_addr} + 32'd1;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [11:0] k;
    k = pc[13:2];
    return {20'h0, k} + 32'd1;
  endfunction

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        jmp;
    logic [31:0] ja;
    logic        en;
    logic [11:0] addr;
    logic        vld;
    logic        cpc;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t tv[$];

  function automatic void v(input int r, input int rd, input int j,
                            input logic [31:0] ja, input int en,
                            input int ad, input int vl, input int cp,
                            input logic [31:0] pc, input int mi);
    vec_t t;
    t.rst  = (r != 0);
    t.rdy  = (rd != 0);
    t.jmp  = (j != 0);
    t.ja   = ja;
    t.en   = (en != 0);
    t.addr = 12'(ad);
    t.vld  = (vl != 0);
    t.cpc  = (cp != 0);
    t.pc   = pc;
    t.mis  = (mi != 0);
    tv.push_back(t);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [31:0] exp_q[$];

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(4 * i));
  endfunction

  task automatic sb_check();
    logic [31:0] e;
    if (if_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got pc %h expected no valid", if_pc);
      end else begin
        e = exp_q[0];
        cmp("sb_pc", if_pc, e);
        cmp("sb_inst", if_inst, rom_word(e));
        if (id_ready) void'(exp_q.pop_front());
      end
    end
  endtask

  logic        hold;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic [31:0] rnd;
  string       tag;

  initial begin
    // reset and startup
    v(0,1,0,0,            0,0,    0,1,32'h0,0);
    v(1,1,0,0,            1,0,    0,1,32'h0,0);
    v(1,1,0,0,            1,1,    0,0,32'h0,0);
    v(1,1,0,0,            1,2,    1,1,32'h0,0);
    v(1,1,0,0,            1,3,    1,1,32'h4,0);
    // five-cycle stall
    for (int i = 0; i < 5; i++) v(1,0,0,0, 0,0, 1,1,32'h8,0);
    v(1,1,0,0,            1,4,    1,1,32'h8,0);
    v(1,1,0,0,            1,5,    1,1,32'hC,0);
    v(1,1,0,0,            1,6,    1,1,32'h10,0);
    // redirect to 0x40 with buffered and in-flight words
    v(1,1,1,32'h40,       0,0,    0,0,32'h0,0);
    v(1,1,0,0,            1,16,   0,0,32'h0,0);
    v(1,1,0,0,            1,17,   0,0,32'h0,0);
    v(1,1,0,0,            1,18,   1,1,32'h40,0);
    v(1,1,0,0,            1,19,   1,1,32'h44,0);
    // misaligned redirect from a full stalled FIFO
    v(1,0,0,0,            0,0,    1,1,32'h48,0);
    v(1,0,0,0,            0,0,    1,1,32'h48,0);
    v(1,1,1,32'h42,       0,0,    0,0,32'h0,0);
    v(1,1,0,0,            1,16,   0,0,32'h0,1);
    v(1,1,0,0,            1,17,   0,0,32'h0,1);
    v(1,1,0,0,            1,18,   1,1,32'h40,1);
    // redirect with pop and returning word in the same cycle
    v(1,1,1,32'h100,      0,0,    0,0,32'h0,1);
    v(1,1,0,0,            1,64,   0,0,32'h0,1);
    v(1,1,0,0,            1,65,   0,0,32'h0,1);
    v(1,1,0,0,            1,66,   1,1,32'h100,1);
    // back-to-back redirects, last one wins
    v(1,1,1,32'h200,      0,0,    0,0,32'h0,1);
    v(1,1,1,32'h300,      0,0,    0,0,32'h0,1);
    v(1,1,0,0,            1,192,  0,0,32'h0,1);
    v(1,1,0,0,            1,193,  0,0,32'h0,1);
    v(1,1,0,0,            1,194,  1,1,32'h300,1);
    v(1,1,0,0,            1,195,  1,1,32'h304,1);
    // reset pulse mid-stream
    v(0,1,0,0,            0,0,    0,1,32'h0,0);
    v(1,1,0,0,            1,0,    0,1,32'h0,0);
    v(1,1,0,0,            1,1,    0,0,32'h0,0);
    v(1,1,0,0,            1,2,    1,1,32'h0,0);
    // PC wrap and ROM address aliasing
    v(1,1,1,32'hFFFF_FFF8,0,0,    0,0,32'h0,0);
    v(1,1,0,0,            1,4094, 0,0,32'h0,0);
    v(1,1,0,0,            1,4095, 0,0,32'h0,0);
    v(1,1,0,0,            1,0,    1,1,32'hFFFF_FFF8,0);
    v(1,1,0,0,            1,1,    1,1,32'hFFFF_FFFC,0);
    v(1,1,0,0,            1,2,    1,1,32'h0,0);

    restart(32'h0);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst       = tv[i].rst;
      id_ready  = tv[i].rdy;
      jump_en   = tv[i].jmp;
      jump_addr = tv[i].ja;
      #1;
      tag = $sformatf("v%0d", i);
      cmp({tag, "_rom_en"}, {31'h0, rom_en}, {31'h0, tv[i].en});
      if (tv[i].en) cmp({tag, "_rom_addr"}, {20'h0, rom_addr}, {20'h0, tv[i].addr});
      cmp({tag, "_valid"}, {31'h0, if_valid}, {31'h0, tv[i].vld});
      if (tv[i].cpc) cmp({tag, "_pc"}, if_pc, tv[i].pc);
      cmp({tag, "_inst"}, if_inst, tv[i].vld ? rom_word(tv[i].pc) : NOP);
      cmp({tag, "_mis"}, {31'h0, misalign_err}, {31'h0, tv[i].mis});
      sb_check();
      if (!tv[i].rst) restart(32'h0);
      else if (tv[i].jmp) restart({tv[i].ja[31:2], 2'b00});
    end

    // random backpressure with occasional redirects
    hold = 1'b0;
    hold_pc = 32'h0;
    hold_inst = 32'h0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      id_ready = 1'($urandom_range(0, 1));
      jump_en  = (c % 30 == 29);
      rnd = $urandom;
      rnd[1:0] = 2'b00;
      jump_addr = rnd;
      #1;
      if (jump_en) begin
        cmp("rj_valid", {31'h0, if_valid}, 32'h0);
        cmp("rj_rom_en", {31'h0, rom_en}, 32'h0);
      end else if (hold) begin
        cmp("stall_valid", {31'h0, if_valid}, 32'h1);
        cmp("stall_pc", if_pc, hold_pc);
        cmp("stall_inst", if_inst, hold_inst);
      end
      sb_check();
      if (jump_en) restart(rnd);
      hold      = if_valid && !id_ready && !jump_en;
      hold_pc   = if_pc;
      hold_inst = if_inst;
    end

    @(negedge clk);
    jump_en  = 1'b0;
    id_ready = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
